// File: rtl/pc_module_if.sv
// ---------------------------------------------------------------------------
// pc_module_pkg / pc_module_if
//
// Purpose:
//   pc_module_pkg holds the next-PC source encodings. The design and anything
//   that drives sig_pc_src share these constants.
//   pc_module_if bundles the program-counter datapath signals that pass
//   between the instruction-sequencing control (master) and pc_module (slave).
//
// Interface signals (WIDTH bits unless noted):
//   PC              : current program counter (slave drives)
//   PC_plus_step    : PC + PC_STEP, combinational link value (slave drives)
//   I_TypeImmediate : signed branch offset, already sign-extended (master drives)
//   J_TypeImmediate : signed jump offset, already sign-extended (master drives)
//   ReturnAddress   : absolute return target (master drives)
//   sig_pc_src      : 2-bit next-PC source select (master drives)
//   pc_write_en     : 1-bit PC update enable (master drives). This signal
//                     exists only when the macro PC_HOLD_EN is defined.
// ---------------------------------------------------------------------------
package pc_module_pkg;
    localparam logic [1:0] pcDefault = 2'b00;  // PC + PC_STEP
    localparam logic [1:0] pcImm     = 2'b01;  // PC + J_TypeImmediate
    localparam logic [1:0] pcSgnImm  = 2'b10;  // PC + I_TypeImmediate
    localparam logic [1:0] pcRET     = 2'b11;  // ReturnAddress
endpackage

interface pc_module_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PC_plus_step;
    logic [WIDTH-1:0] I_TypeImmediate;
    logic [WIDTH-1:0] J_TypeImmediate;
    logic [WIDTH-1:0] ReturnAddress;
    logic [1:0]       sig_pc_src;
`ifdef PC_HOLD_EN
    logic             pc_write_en;
`endif

    // Control side: selects the next PC and consumes PC / link value.
    modport master (
        input  PC,
        input  PC_plus_step,
        output I_TypeImmediate,
        output J_TypeImmediate,
        output ReturnAddress,
`ifdef PC_HOLD_EN
        output pc_write_en,
`endif
        output sig_pc_src
    );

    // Program-counter side.
    modport slave (
        output PC,
        output PC_plus_step,
        input  I_TypeImmediate,
        input  J_TypeImmediate,
        input  ReturnAddress,
`ifdef PC_HOLD_EN
        input  pc_write_en,
`endif
        input  sig_pc_src
    );
endinterface

// File: rtl/pc_module.sv
// ---------------------------------------------------------------------------
// pc_module
//
// Purpose:
//   This module holds the registered program counter. The next-PC value comes
//   from a combinational mux: sequential step, relative jump, relative branch,
//   or absolute return. PC loads this value on the rising clock edge, so PC
//   follows its select and data inputs one cycle later. All arithmetic wraps
//   modulo 2^WIDTH and gives no overflow indication. The immediates are used
//   as-is. They are assumed to be already sign-extended to WIDTH, and the
//   module does not shift or scale them.
//
// Parameters:
//   WIDTH    : width of the PC, the immediates and the return address
//   PC_STEP  : sequential increment in bytes
//   RESET_PC : value that PC loads during reset
//
// Ports:
//   clock   : rising-edge clock for all state
//   reset_n : synchronous active-low reset. It takes priority over every
//             other input.
//   bus     : pc_module_if slave modport (PC, PC_plus_step, immediates,
//             ReturnAddress, sig_pc_src, optional pc_write_en)
//
// Configuration:
//   PC_HOLD_EN : when this macro is defined, bus.pc_write_en gates the PC
//                update, and PC holds its value on edges where the enable is
//                low. Reset still wins over the enable. When the macro is not
//                defined, PC updates on every edge that is not a reset edge.
// ---------------------------------------------------------------------------
module pc_module #(
    parameter int                 WIDTH    = 16,
    parameter int                 PC_STEP  = 2,
    parameter logic [WIDTH-1:0]   RESET_PC = {WIDTH{1'b0}}
) (
    input  logic        clock,
    input  logic        reset_n,
    pc_module_if.slave  bus
);
    import pc_module_pkg::*;

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_plus_step;

    // The link value is derived from the registered PC only. During reset,
    // pc_reg already holds RESET_PC, so the link value is RESET_PC + STEP.
    assign pc_plus_step = pc_reg + STEP;

    // Next-PC mux. Any select value outside the four legal codes (for
    // example X in simulation) falls back to the sequential step.
    always_comb begin
        pc_next = pc_plus_step;
        case (bus.sig_pc_src)
            pcDefault: pc_next = pc_plus_step;
            pcImm:     pc_next = pc_reg + bus.J_TypeImmediate;
            pcSgnImm:  pc_next = pc_reg + bus.I_TypeImmediate;
            pcRET:     pc_next = bus.ReturnAddress;
            default:   pc_next = pc_plus_step;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_reg <= RESET_PC;
`ifdef PC_HOLD_EN
        end else if (bus.pc_write_en) begin
            pc_reg <= pc_next;
        end
`else
        end else begin
            pc_reg <= pc_next;
        end
`endif
    end

    assign bus.PC           = pc_reg;
    assign bus.PC_plus_step = pc_plus_step;

endmodule

// File: tb/tb_pc_module.sv
// ---------------------------------------------------------------------------
// tb_pc_module : self-checking bench for pc_module (WIDTH=16, PC_STEP=2,
// RESET_PC=0). The bench pushes each expected PC and link value to a
// scoreboard queue when it drives the stimulus. After the next rising edge,
// it pops the entry and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_pc_module;
    import pc_module_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] plus;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    logic last_we;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];
    exp_t got;
    logic [W-1:0] model_pc;

    pc_module_if #(.WIDTH(W)) bus ();

    pc_module #(
        .WIDTH   (W),
        .PC_STEP (2),
        .RESET_PC(16'h0000)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // Pushes the expected value for the coming edge.
    task automatic push_exp(input logic [W-1:0] pc);
        exp_t e;
        e.pc   = pc;
        e.plus = pc + 16'd2;
        sb_q.push_back(e);
        model_pc = pc;
    endtask

    // Drives inputs on the falling edge, then returns 1 time unit after the
    // next rising edge.
    task automatic drive_edge(input logic rst_n, input logic [1:0] sel,
                              input logic [W-1:0] j, input logic [W-1:0] i,
                              input logic [W-1:0] ret, input logic we);
        @(negedge clock);
        reset_n             = rst_n;
        bus.sig_pc_src      = sel;
        bus.J_TypeImmediate = j;
        bus.I_TypeImmediate = i;
        bus.ReturnAddress   = ret;
        last_we             = we;
`ifdef PC_HOLD_EN
        bus.pc_write_en     = we;
`endif
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        push_exp(16'h0000);
        drive_edge(1'b0, pcRET, 16'h0, 16'h0, 16'h1234, 1'b1);
        got = sb_q.pop_front();
        vectors++;
        if (bus.PC !== got.pc || bus.PC_plus_step !== got.plus) begin
            miscompares++;
            $display("FAIL reset: PC=%h link=%h, want PC=%h link=%h",
                     bus.PC, bus.PC_plus_step, got.pc, got.plus);
        end else
            $display("reset: PC=%h link=%h", bus.PC, bus.PC_plus_step);
    endtask

    task automatic test_seq_ret();
        logic [1:0]   sel [2] = '{pcDefault, pcRET};
        logic [W-1:0] ret [2] = '{16'hAAAA, 16'h0002};
        logic [W-1:0] exp [2] = '{16'h0002, 16'h0002};
        for (int k = 0; k < 2; k++) begin
            push_exp(exp[k]);
            drive_edge(1'b1, sel[k], 16'h0, 16'h0, ret[k], 1'b1);
            got = sb_q.pop_front();
            vectors++;
            if (bus.PC !== got.pc || bus.PC_plus_step !== got.plus) begin
                miscompares++;
                $display("FAIL seq_ret[%0d]: PC=%h link=%h, want PC=%h link=%h",
                         k, bus.PC, bus.PC_plus_step, got.pc, got.plus);
            end else
                $display("seq_ret[%0d]: PC=%h", k, bus.PC);
        end
    endtask

    task automatic test_jump();
        logic [W-1:0] j   [2] = '{16'd10, 16'hFFF6};
        logic [W-1:0] exp [2] = '{16'd12, 16'd2};
        for (int k = 0; k < 2; k++) begin
            push_exp(exp[k]);
            drive_edge(1'b1, pcImm, j[k], 16'h5555, 16'h0, 1'b1);
            got = sb_q.pop_front();
            vectors++;
            if (bus.PC !== got.pc || bus.PC_plus_step !== got.plus) begin
                miscompares++;
                $display("FAIL jump[%0d]: PC=%h link=%h, want PC=%h link=%h",
                         k, bus.PC, bus.PC_plus_step, got.pc, got.plus);
            end else
                $display("jump[%0d]: PC=%h", k, bus.PC);
        end
    endtask

    task automatic test_branch();
        logic [W-1:0] i   [2] = '{16'd8, 16'hFFF4};
        logic [W-1:0] exp [2] = '{16'd10, 16'hFFFE};
        for (int k = 0; k < 2; k++) begin
            push_exp(exp[k]);
            drive_edge(1'b1, pcSgnImm, 16'h3333, i[k], 16'h0, 1'b1);
            got = sb_q.pop_front();
            vectors++;
            if (bus.PC !== got.pc || bus.PC_plus_step !== got.plus) begin
                miscompares++;
                $display("FAIL branch[%0d]: PC=%h link=%h, want PC=%h link=%h",
                         k, bus.PC, bus.PC_plus_step, got.pc, got.plus);
            end else
                $display("branch[%0d]: PC=%h", k, bus.PC);
        end
    endtask

    // Tests wrap from FFFE, a reset that overrides pcRET from a nonzero PC,
    // and resumption on the first edge with reset released.
    task automatic test_wrap_reset();
        logic         rst [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0]   sel [4] = '{pcDefault, pcRET, pcRET, pcDefault};
        logic [W-1:0] ret [4] = '{16'h0, 16'h1234, 16'hBEEF, 16'h0};
        logic [W-1:0] exp [4] = '{16'h0000, 16'h1234, 16'h0000, 16'h0002};
        for (int k = 0; k < 4; k++) begin
            push_exp(exp[k]);
            drive_edge(rst[k], sel[k], 16'h0, 16'h0, ret[k], 1'b1);
            got = sb_q.pop_front();
            vectors++;
            if (bus.PC !== got.pc || bus.PC_plus_step !== got.plus) begin
                miscompares++;
                $display("FAIL wrap_reset[%0d]: PC=%h link=%h, want PC=%h link=%h",
                         k, bus.PC, bus.PC_plus_step, got.pc, got.plus);
            end else
                $display("wrap_reset[%0d]: PC=%h", k, bus.PC);
        end
    endtask

`ifdef PC_HOLD_EN
    task automatic test_hold();
        logic         rst [3] = '{1'b1, 1'b1, 1'b0};
        logic         we  [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] exp [3] = '{16'd2, 16'd12, 16'd0};
        for (int k = 0; k < 3; k++) begin
            push_exp(exp[k]);
            drive_edge(rst[k], pcImm, 16'd10, 16'h0, 16'h0, we[k]);
            got = sb_q.pop_front();
            vectors++;
            if (bus.PC !== got.pc || bus.PC_plus_step !== got.plus) begin
                miscompares++;
                $display("FAIL hold[%0d]: PC=%h link=%h, want PC=%h link=%h",
                         k, bus.PC, bus.PC_plus_step, got.pc, got.plus);
            end else
                $display("hold[%0d]: PC=%h", k, bus.PC);
        end
    endtask
`endif

    // Runs back-to-back random edges against a reference next-PC model.
    task automatic test_back_to_back();
        logic [1:0]   sel;
        logic [W-1:0] j, i, ret, nxt;
        logic         rst, we;
        for (int k = 0; k < 60; k++) begin
            sel = 2'($urandom_range(0, 3));
            j   = W'($urandom);
            i   = W'($urandom);
            ret = W'($urandom);
            rst = ($urandom_range(0, 15) != 0);
`ifdef PC_HOLD_EN
            we  = ($urandom_range(0, 3) != 0);
`else
            we  = 1'b1;
`endif
            case (sel)
                pcImm:    nxt = model_pc + j;
                pcSgnImm: nxt = model_pc + i;
                pcRET:    nxt = ret;
                default:  nxt = model_pc + 16'd2;
            endcase
            if (!rst)     nxt = 16'h0000;
            else if (!we) nxt = model_pc;
            push_exp(nxt);
            drive_edge(rst, sel, j, i, ret, we);
            got = sb_q.pop_front();
            vectors++;
            if (bus.PC !== got.pc || bus.PC_plus_step !== got.plus) begin
                miscompares++;
                $display("FAIL b2b[%0d] sel=%0d rst_n=%0b: PC=%h link=%h, want PC=%h link=%h",
                         k, sel, rst, bus.PC, bus.PC_plus_step, got.pc, got.plus);
            end else
                $display("b2b[%0d] sel=%0d rst_n=%0b we=%0b: PC=%h", k, sel, rst, last_we, bus.PC);
        end
    endtask

    initial begin
        reset_n             = 1'b0;
        bus.sig_pc_src      = pcDefault;
        bus.J_TypeImmediate = '0;
        bus.I_TypeImmediate = '0;
        bus.ReturnAddress   = '0;
        last_we             = 1'b1;
        model_pc            = '0;
`ifdef PC_HOLD_EN
        bus.pc_write_en     = 1'b1;
`endif
        test_reset();
        test_seq_ret();
        test_jump();
        test_branch();
        test_wrap_reset();
`ifdef PC_HOLD_EN
        test_hold();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_module.md
PC_MODULE -- requirements
Module: pc_module

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, the bit width of the PC, immediates and return address.
REQ-002 The module SHALL have parameter PC_STEP, default 2, the sequential PC increment in bytes.
REQ-003 The module SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-004 The module SHALL have one clock and a reset that is synchronous and active-low.
REQ-005 Port clock  input  1  rising-edge clock for all state.
REQ-006 Port reset_n  input  1  synchronous active-low reset.
REQ-007 Port PC  output  WIDTH  current program counter, registered.
REQ-008 Port I_TypeImmediate  input  WIDTH  signed two's-complement branch offset.
REQ-009 Port J_TypeImmediate  input  WIDTH  signed two's-complement jump offset.
REQ-010 Port ReturnAddress  input  WIDTH  absolute return target.
REQ-011 Port sig_pc_src  input  2  next-PC source select.
REQ-012 Port PC_plus_step  output  WIDTH  combinational PC + PC_STEP, used as the link value.
REQ-013 Port pc_write_en  input  1  PC update enable; present only when PC_HOLD_EN is defined.

Function
REQ-014 sig_pc_src encodings SHALL be: pcDefault=2'b00, pcImm=2'b01, pcSgnImm=2'b10, pcRET=2'b11, taken from the shared constants file.
REQ-015 pcDefault SHALL load PC + PC_STEP.
REQ-016 pcImm SHALL load PC + J_TypeImmediate, a signed relative jump.
REQ-017 pcSgnImm SHALL load PC + I_TypeImmediate, the taken-branch target.
REQ-018 pcRET SHALL load ReturnAddress unchanged.
REQ-019 The next-PC mux SHALL be combinational, and PC SHALL update only on the rising clock edge (latency 1 cycle from select/inputs to PC).
REQ-020 Inputs sampled SHALL be those stable at the rising edge; input changes between edges SHALL NOT affect PC.
REQ-021 All additions SHALL be modulo 2^WIDTH: wrap-around is silent, with no overflow flag.
REQ-022 Immediates SHALL be treated as already sign-extended to WIDTH, with no internal shifting or scaling.
REQ-023 PC_plus_step SHALL always equal PC + PC_STEP (mod 2^WIDTH) regardless of sig_pc_src.
REQ-024 An X or undefined select value is not a legal input, and synthesis SHALL map the default case to pcDefault.

Reset
REQ-025 When reset_n is low at a rising edge, PC SHALL become RESET_PC, overriding sig_pc_src and pc_write_en.
REQ-026 Reset deasserted mid-operation SHALL resume normal next-PC selection on the first edge with reset_n high.
REQ-027 PC_plus_step SHALL read RESET_PC + PC_STEP while in reset.

Configuration
REQ-028 Macro PC_HOLD_EN: when defined, the pc_write_en port SHALL exist, and PC SHALL hold its value on edges where pc_write_en=0 (reset still wins).
REQ-029 Without PC_HOLD_EN, the port SHALL be absent and PC SHALL update on every non-reset edge.

Verification
REQ-030 Reset: reset_n=0 for one edge -> PC=0, PC_plus_step=2.
REQ-031 Sequential and return: from PC=0, pcDefault, one edge -> PC=2; then pcRET, ReturnAddress=2 -> PC=2.
REQ-032 Jump both directions: PC=2, pcImm, J_TypeImmediate=10 -> PC=12; then J_TypeImmediate=-10 -> PC=2.
REQ-033 Branch: PC=2, pcSgnImm, I_TypeImmediate=8 -> PC=10; I_TypeImmediate=-12 from PC=10 -> PC=16'hFFFE.
REQ-034 Wrap: PC=16'hFFFE, pcDefault -> PC=0; reset asserted simultaneously with pcRET -> PC=0.
REQ-035 With PC_HOLD_EN: pc_write_en=0, pcImm, J_TypeImmediate=10 -> PC unchanged; pc_write_en=1 -> PC+10.
